// File: rtl/pe_mode1_sequencer.sv
// ============================================================================
//  Module   : pe_mode1_sequencer
//  Purpose  : Mode-1 load sequencer for a PE array. It configures the array,
//             streams a block of weight words and one fmap tile per pass from
//             two valid/ready sources, waits for the shift-finish handshake
//             between passes and for clip-finish at the end, then requests the
//             partial-sum readout.
//  Ports    : clk, rst_n                      clock, async active-low reset
//             i_go, i_abort                   start pulse, synchronous abort
//             i_w_total, i_f_words, i_n_pass  job sizes, latched on start
//             i_w_src_*, o_w_src_ready        weight source stream
//             i_f_src_*, o_f_src_ready        fmap source stream
//             o_weight_in*, o_feature_in*     PE write ports (zero latency)
//             i_fifo_full_*, i_*_finish_flg   PE status
//             o_start_*, o_load_full_cloumn   PE control strobes
//             o_busy, o_done, o_pass_idx      sequencer status
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pe_mode1_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_go,
   input  logic                  i_abort,
   input  logic [CNT_WIDTH-1:0]  i_w_total,
   input  logic [CNT_WIDTH-1:0]  i_f_words,
   input  logic [CNT_WIDTH-1:0]  i_n_pass,
   input  logic [DATA_WIDTH-1:0] i_w_src_data,
   input  logic                  i_w_src_valid,
   output logic                  o_w_src_ready,
   input  logic [DATA_WIDTH-1:0] i_f_src_data,
   input  logic                  i_f_src_valid,
   output logic                  o_f_src_ready,
   output logic [DATA_WIDTH-1:0] o_weight_in,
   output logic                  o_weight_in_en,
   output logic [DATA_WIDTH-1:0] o_feature_in,
   output logic                  o_feature_in_en,
   input  logic                  i_fifo_full_filter,
   input  logic                  i_fifo_full_fmap,
   input  logic                  i_shift_finish_flg,
   input  logic                  i_clip_finish_flg,
   output logic                  o_start_config,
   output logic                  o_start_weight_load,
   output logic                  o_start_feature_load,
   output logic                  o_load_full_cloumn,
   output logic                  o_start_psum_out,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [CNT_WIDTH-1:0]  o_pass_idx
);

   typedef enum logic [3:0] {
      S_IDLE        = 4'd0,
      S_CONFIG      = 4'd1,
      S_LOAD        = 4'd2,
      S_STREAM      = 4'd3,
      S_WAIT_SHIFT  = 4'd4,
      S_FEAT_START  = 4'd5,
      S_FEAT_STREAM = 4'd6,
      S_WAIT_CLIP   = 4'd7,
      S_PSUM_OUT    = 4'd8,
      S_DONE        = 4'd9
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_WIDTH-1:0] r_w_total;
   logic [CNT_WIDTH-1:0] r_f_words;
   logic [CNT_WIDTH-1:0] r_n_pass;
   logic [CNT_WIDTH-1:0] r_w_cnt;
   logic [CNT_WIDTH-1:0] r_f_cnt;
   logic [CNT_WIDTH-1:0] r_pass_idx;
   logic                 r_shift_seen;
   logic                 r_clip_seen;

   logic                 w_in_stream;
   logic                 w_in_feat;
   logic                 w_w_ready;
   logic                 w_f_ready;
   logic                 w_w_xfer;
   logic                 w_f_xfer;
   logic                 w_stream_exit;
   logic                 w_last_pass;
   logic [CNT_WIDTH:0]   w_pass_inc;
   logic [CNT_WIDTH-1:0] w_n_pass_eff;

   assign w_in_stream = (r_state == S_STREAM);
   assign w_in_feat   = (r_state == S_FEAT_STREAM);

   // Readiness is gated by the remaining count so a counter can never pass
   // its total, and by the PE fifo status of the same cycle.
   assign w_w_ready = w_in_stream & ~i_fifo_full_filter & (r_w_cnt < r_w_total);
   assign w_f_ready = (w_in_stream | w_in_feat) & ~i_fifo_full_fmap
                      & (r_f_cnt < r_f_words);
   assign w_w_xfer  = i_w_src_valid & w_w_ready;
   assign w_f_xfer  = i_f_src_valid & w_f_ready;

   // The first pass streams weights and fmap together; later passes only fmap.
   assign w_stream_exit = (w_in_stream & (r_w_cnt == r_w_total) & (r_f_cnt == r_f_words))
                        | (w_in_feat & (r_f_cnt == r_f_words));

   // One extra bit so the pass+1 comparison cannot wrap.
   assign w_pass_inc   = {1'b0, r_pass_idx} + 1'b1;
   assign w_last_pass  = (w_pass_inc >= {1'b0, r_n_pass});
   assign w_n_pass_eff = (i_n_pass == '0) ? CNT_WIDTH'(1) : i_n_pass;

   always_comb begin
      w_state_nxt = r_state;
      if (i_abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:        if (i_go) w_state_nxt = S_CONFIG;
            S_CONFIG:      w_state_nxt = S_LOAD;
            S_LOAD:        w_state_nxt = S_STREAM;
            S_STREAM,
            S_FEAT_STREAM: if (w_stream_exit)
                              w_state_nxt = w_last_pass ? S_WAIT_CLIP : S_WAIT_SHIFT;
            S_WAIT_SHIFT:  if (r_shift_seen | i_shift_finish_flg) w_state_nxt = S_FEAT_START;
            S_FEAT_START:  w_state_nxt = S_FEAT_STREAM;
            S_WAIT_CLIP:   if (r_clip_seen | i_clip_finish_flg) w_state_nxt = S_PSUM_OUT;
            S_PSUM_OUT:    w_state_nxt = S_DONE;
            S_DONE:        w_state_nxt = S_IDLE;
            default:       w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_w_total    <= '0;
         r_f_words    <= '0;
         r_n_pass     <= '0;
         r_w_cnt      <= '0;
         r_f_cnt      <= '0;
         r_pass_idx   <= '0;
         r_shift_seen <= 1'b0;
         r_clip_seen  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (i_abort) begin
            r_w_cnt      <= '0;
            r_f_cnt      <= '0;
            r_pass_idx   <= '0;
            r_shift_seen <= 1'b0;
            r_clip_seen  <= 1'b0;
         end else if ((r_state == S_IDLE) && i_go) begin
            r_w_total    <= i_w_total;
            r_f_words    <= i_f_words;
            r_n_pass     <= w_n_pass_eff;
            r_w_cnt      <= '0;
            r_f_cnt      <= '0;
            r_pass_idx   <= '0;
            r_shift_seen <= 1'b0;
            r_clip_seen  <= 1'b0;
         end else begin
            if (w_w_xfer) r_w_cnt <= r_w_cnt + 1'b1;
            // Exit requires f_cnt at its total, so no transfer can coincide.
            if (w_stream_exit)  r_f_cnt <= '0;
            else if (w_f_xfer)  r_f_cnt <= r_f_cnt + 1'b1;
            if (w_stream_exit && !w_last_pass) r_pass_idx <= w_pass_inc[CNT_WIDTH-1:0];
            // A shift-finish that arrives while streaming is remembered so the
            // following WAIT_SHIFT does not have to see the flag live.
            if ((r_state == S_WAIT_SHIFT) && (w_state_nxt != S_WAIT_SHIFT))
               r_shift_seen <= 1'b0;
            else if (i_shift_finish_flg && (w_in_stream || w_in_feat || (r_state == S_WAIT_SHIFT)))
               r_shift_seen <= 1'b1;
            if (i_clip_finish_flg && (r_state != S_IDLE)) r_clip_seen <= 1'b1;
         end
      end
   end

   assign o_w_src_ready        = w_w_ready;
   assign o_f_src_ready        = w_f_ready;
   assign o_weight_in_en       = w_w_xfer;
   assign o_feature_in_en      = w_f_xfer;
   // Data is forced to zero when not writing so the port is quiet in reset/idle.
   assign o_weight_in          = w_w_xfer ? i_w_src_data : '0;
   assign o_feature_in         = w_f_xfer ? i_f_src_data : '0;
   assign o_start_config       = (r_state == S_CONFIG);
   assign o_start_weight_load  = (r_state == S_LOAD);
   assign o_start_feature_load = (r_state == S_LOAD) | (r_state == S_FEAT_START);
   assign o_load_full_cloumn   = (r_state != S_IDLE) & (r_state != S_DONE);
   assign o_start_psum_out     = (r_state == S_PSUM_OUT);
   assign o_busy               = (r_state != S_IDLE);
   assign o_done               = (r_state == S_DONE);
   assign o_pass_idx           = r_pass_idx;

endmodule

`default_nettype wire

// File: tb/tb_pe_mode1_sequencer.sv
// ============================================================================
//  Module   : tb_pe_mode1_sequencer
//  Purpose  : Self-checking bench for pe_mode1_sequencer. Sources emit
//             numbered words; a transaction-level model derives expected
//             write counts, word order, strobe counts and event ordering from
//             the job parameters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pe_mode1_sequencer;

   localparam int DW = 16;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_go, i_abort;
   logic [CW-1:0] i_w_total, i_f_words, i_n_pass;
   logic [DW-1:0] i_w_src_data, i_f_src_data;
   logic          i_w_src_valid, i_f_src_valid;
   logic          o_w_src_ready, o_f_src_ready;
   logic [DW-1:0] o_weight_in, o_feature_in;
   logic          o_weight_in_en, o_feature_in_en;
   logic          i_fifo_full_filter, i_fifo_full_fmap;
   logic          i_shift_finish_flg, i_clip_finish_flg;
   logic          o_start_config, o_start_weight_load, o_start_feature_load;
   logic          o_load_full_cloumn, o_start_psum_out, o_busy, o_done;
   logic [CW-1:0] o_pass_idx;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pe_mode1_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .i_go                 (i_go),
      .i_abort              (i_abort),
      .i_w_total            (i_w_total),
      .i_f_words            (i_f_words),
      .i_n_pass             (i_n_pass),
      .i_w_src_data         (i_w_src_data),
      .i_w_src_valid        (i_w_src_valid),
      .o_w_src_ready        (o_w_src_ready),
      .i_f_src_data         (i_f_src_data),
      .i_f_src_valid        (i_f_src_valid),
      .o_f_src_ready        (o_f_src_ready),
      .o_weight_in          (o_weight_in),
      .o_weight_in_en       (o_weight_in_en),
      .o_feature_in         (o_feature_in),
      .o_feature_in_en      (o_feature_in_en),
      .i_fifo_full_filter   (i_fifo_full_filter),
      .i_fifo_full_fmap     (i_fifo_full_fmap),
      .i_shift_finish_flg   (i_shift_finish_flg),
      .i_clip_finish_flg    (i_clip_finish_flg),
      .o_start_config       (o_start_config),
      .o_start_weight_load  (o_start_weight_load),
      .o_start_feature_load (o_start_feature_load),
      .o_load_full_cloumn   (o_load_full_cloumn),
      .o_start_psum_out     (o_start_psum_out),
      .o_busy               (o_busy),
      .o_done               (o_done),
      .o_pass_idx           (o_pass_idx)
   );

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {13'd0, o_weight_in, o_feature_in, o_w_src_ready, o_f_src_ready,
              o_weight_in_en, o_feature_in_en, o_start_config, o_start_weight_load,
              o_start_feature_load, o_load_full_cloumn, o_start_psum_out,
              o_busy, o_done, o_pass_idx};
   endfunction

   // One job. Called half a step after a rising edge. early=1 issues the
   // shift/clip flags right after each feature-load strobe (during streaming).
   task automatic run_op(input int wt, input int fw, input int np, input int vpct,
                         input int ffmode, input int fmpct, input bit early,
                         input int abort_at, input bit rst_feat);
      int npe, cyc, cfg, wl, fl, ps, dn, viol, errs;
      int clip_cyc, ps_cyc, dn_cyc, last_wr, pass_f, shifts, sh_timer, cl_timer;
      int wdata, fdata, ab_state, post;
      int wq[$];
      int fq[$];
      bit stop, w_seen, f_seen;
      logic [4:0]  cur_p, prev_p;
      logic [63:0] acc;
      npe = (np == 0) ? 1 : np;
      cyc = 0; cfg = 0; wl = 0; fl = 0; ps = 0; dn = 0; viol = 0;
      clip_cyc = -1; ps_cyc = -1; dn_cyc = -1; last_wr = 0; pass_f = 0;
      shifts = 0; sh_timer = 0; cl_timer = 0; wdata = 1; fdata = 1;
      ab_state = 0; post = 0; stop = 0; prev_p = '0; w_seen = 0; f_seen = 0;
      i_w_total = wt[CW-1:0]; i_f_words = fw[CW-1:0]; i_n_pass = np[CW-1:0];
      i_go = 1'b1; i_abort = 1'b0;
      i_w_src_data = wdata[DW-1:0]; i_f_src_data = fdata[DW-1:0];
      i_w_src_valid = 1'b0; i_f_src_valid = 1'b0;
      i_fifo_full_filter = 1'b0; i_fifo_full_fmap = 1'b0;
      i_shift_finish_flg = 1'b0; i_clip_finish_flg = 1'b0;
      while (!stop && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         cur_p = {o_start_config, o_start_weight_load, o_start_feature_load,
                  o_start_psum_out, o_done};
         if ((cur_p & prev_p) != 5'd0) viol++;
         prev_p = cur_p;
         if (o_load_full_cloumn !== (o_busy & ~o_done)) viol++;
         if (o_weight_in_en !== (i_w_src_valid & o_w_src_ready)) viol++;
         if (o_feature_in_en !== (i_f_src_valid & o_f_src_ready)) viol++;
         if ((o_weight_in_en & i_fifo_full_filter) || (o_feature_in_en & i_fifo_full_fmap)) viol++;
         w_seen = o_weight_in_en;
         f_seen = o_feature_in_en;
         if (w_seen) begin wq.push_back(int'(o_weight_in)); last_wr = cyc; end
         if (f_seen) begin fq.push_back(int'(o_feature_in)); pass_f++; last_wr = cyc; end
         if (o_start_config) cfg++;
         if (o_start_weight_load) wl++;
         if (o_start_feature_load) begin
            fl++;
            if (fl > 1) begin
               check_eq("pass_fmap_words", pass_f, fw);
               check_eq("shift_before_fload", shifts > 0, 1);
               if (early) check_eq("fload_latency_ok", (cyc - last_wr) <= 3, 1);
            end
            pass_f = 0; shifts = 0;
            sh_timer = early ? 1 : 0;
            if (early && fl == npe) cl_timer = 1;
         end
         if (o_start_psum_out) begin
            ps++; ps_cyc = cyc;
            check_eq("last_pass_fmap_words", pass_f, fw);
            check_eq("psum_after_clip", (clip_cyc >= 0) && (cyc >= clip_cyc + 2), 1);
            if (early) check_eq("psum_latency_ok", (cyc - last_wr) <= 3, 1);
         end
         if (o_done) begin dn++; dn_cyc = cyc; end
         if (dn_cyc > 0 && cyc == dn_cyc + 2) begin
            check_eq("idle_after_done", o_busy, 0);
            stop = 1;
         end
         if (ab_state == 2) begin
            check_eq("abort_busy", o_busy, 0);
            check_eq("abort_readies", {o_w_src_ready, o_f_src_ready}, 0);
            ab_state = 3; post = cyc;
         end
         if (ab_state == 3 && cyc == post + 5) stop = 1;
         if (stop) break;
         @(posedge clk);
         #1;
         if (rst_feat && fl == 2 && pass_f >= 3) begin
            i_w_src_valid = 1'b1; i_f_src_valid = 1'b1;
            i_fifo_full_filter = 1'b0; i_fifo_full_fmap = 1'b0;
            #1 rst_n = 1'b0;
            #1 check_eq("rst_async_outputs", longint'(all_outs()), 0);
            @(posedge clk);
            #1 rst_n = 1'b1;
            acc = '0;
            repeat (3) begin @(negedge clk); acc |= all_outs(); end
            check_eq("rst_release_quiet", longint'(acc), 0);
            stop = 1;
            break;
         end
         // Late go requests with different sizes must be ignored while busy.
         i_go = (abort_at == 0 && !rst_feat && dn == 0 && $urandom_range(0, 99) < 3);
         i_w_total = CW'($urandom); i_f_words = CW'($urandom); i_n_pass = CW'($urandom);
         if (w_seen) wdata++;
         if (f_seen) fdata++;
         i_w_src_data = wdata[DW-1:0];
         i_f_src_data = fdata[DW-1:0];
         i_w_src_valid = ($urandom_range(0, 99) < vpct);
         i_f_src_valid = ($urandom_range(0, 99) < vpct);
         i_fifo_full_filter = (ffmode == 1) ? (cyc % 3 == 0) :
                              (ffmode == 2) ? ($urandom_range(0, 99) < 25) : 1'b0;
         i_fifo_full_fmap = ($urandom_range(0, 99) < fmpct);
         i_shift_finish_flg = early ? (sh_timer == 1) : ($urandom_range(0, 99) < 8);
         sh_timer = 0;
         if (i_shift_finish_flg) shifts++;
         i_clip_finish_flg = early ? (cl_timer == 1) : ($urandom_range(0, 99) < 5);
         cl_timer = 0;
         if (i_clip_finish_flg && clip_cyc < 0) clip_cyc = cyc;
         i_abort = 1'b0;
         if (ab_state == 1) ab_state = 2;
         else if (abort_at > 0 && ab_state == 0 && wq.size() == abort_at) begin
            i_abort = 1'b1; i_w_src_valid = 1'b0; ab_state = 1;
         end
      end
      i_go = 1'b0; i_abort = 1'b0;
      i_shift_finish_flg = 1'b0; i_clip_finish_flg = 1'b0;
      check_eq("op_completed", stop, 1);
      if (rst_feat) return;
      if (abort_at > 0) begin
         check_eq("abort_no_done", dn, 0);
         check_eq("abort_weight_words", wq.size(), abort_at);
         check_eq("abort_protocol", viol, 0);
         return;
      end
      errs = 0;
      foreach (wq[i]) if (wq[i] != i + 1) errs++;
      check_eq("weight_order", errs, 0);
      errs = 0;
      foreach (fq[i]) if (fq[i] != i + 1) errs++;
      check_eq("fmap_order", errs, 0);
      check_eq("weight_words", wq.size(), wt);
      check_eq("fmap_words", fq.size(), npe * fw);
      check_eq("start_config_cnt", cfg, 1);
      check_eq("start_wload_cnt", wl, 1);
      check_eq("start_fload_cnt", fl, npe);
      check_eq("start_psum_cnt", ps, 1);
      check_eq("done_cnt", dn, 1);
      check_eq("done_after_psum", dn_cyc - ps_cyc, 1);
      check_eq("protocol", viol, 0);
   endtask

   initial begin
      rst_n = 1'b0; i_go = 1'b0; i_abort = 1'b0;
      i_w_total = '0; i_f_words = '0; i_n_pass = '0;
      i_w_src_data = '0; i_f_src_data = '0;
      i_w_src_valid = 1'b0; i_f_src_valid = 1'b0;
      i_fifo_full_filter = 1'b0; i_fifo_full_fmap = 1'b0;
      i_shift_finish_flg = 1'b0; i_clip_finish_flg = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_outputs", longint'(all_outs()), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("release_idle", longint'(all_outs()), 0);

      // Nominal mode-1 job with shift/clip flags arriving early.
      @(posedge clk); #1;
      run_op(102, 12, 3, 100, 0, 0, 1'b1, 0, 1'b0);
      // Filter fifo full one cycle in three.
      @(posedge clk); #1;
      run_op(102, 12, 3, 100, 1, 0, 1'b0, 0, 1'b0);
      // Abort after 40 weight words, then abort beating go, then a clean restart.
      @(posedge clk); #1;
      run_op(102, 12, 3, 100, 0, 0, 1'b0, 40, 1'b0);
      @(posedge clk); #1;
      i_go = 1'b1; i_abort = 1'b1; i_w_total = 8'd5; i_f_words = 8'd2; i_n_pass = 8'd1;
      @(posedge clk); #1;
      i_go = 1'b0; i_abort = 1'b0;
      @(negedge clk);
      check_eq("abort_beats_go", o_busy, 0);
      @(posedge clk); #1;
      run_op(102, 12, 3, 100, 0, 0, 1'b0, 0, 1'b0);
      // Reset during the second pass fmap stream.
      @(posedge clk); #1;
      run_op(20, 8, 3, 100, 0, 0, 1'b0, 0, 1'b1);
      // Degenerate sizes: no passes given, no weights.
      @(posedge clk); #1;
      run_op(0, 4, 0, 100, 0, 0, 1'b0, 0, 1'b0);
      // Randomised jobs with source stalls and fifo backpressure.
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         run_op($urandom_range(0, 40), $urandom_range(0, 10), $urandom_range(0, 4),
                $urandom_range(50, 100), 2, $urandom_range(0, 30), 1'b0, 0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pe_mode1_sequencer.md
PE_MODE1_SEQUENCER -- requirements
Module: pe_mode1_sequencer

Interface
REQ-001 Parameters: DATA_WIDTH=16 (stream word width); CNT_WIDTH=8 (word/pass counter width).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 go / abort  in  1 each  start pulse / synchronous abort.
REQ-005 w_total, f_words, n_pass  in  CNT_WIDTH each  weight words, fmap words per pass, pass count; latched on accepted go.
REQ-006 w_src_data / f_src_data  in  DATA_WIDTH; w_src_valid / f_src_valid  in  1; w_src_ready / f_src_ready  out  1: source streams.
REQ-007 weight_in / feature_in  out  DATA_WIDTH; weight_in_en / feature_in_en  out  1: PE write ports.
REQ-008 fifo_full_filter, fifo_full_fmap, shift_finish_flg, clip_finish_flg  in  1: PE status.
REQ-009 start_config, start_weight_load, start_feature_load, load_full_cloumn, start_psum_out  out  1: PE controls.
REQ-010 busy, done  out  1: status; pass_idx  out  CNT_WIDTH: current pass.

Function
REQ-011 FSM states: IDLE, CONFIG, LOAD, STREAM, WAIT_SHIFT, FEAT_START, FEAT_STREAM, WAIT_CLIP, PSUM_OUT, DONE.
REQ-012 IDLE: go=1 latches parameters, clears counters, moves to CONFIG; go outside IDLE is ignored.
REQ-013 CONFIG: start_config=1 for exactly one cycle -> LOAD.
REQ-014 LOAD: start_weight_load=1 and start_feature_load=1 for one cycle -> STREAM.
REQ-015 load_full_cloumn=1 in every state except IDLE and DONE.
REQ-016 w_src_ready = (STREAM) & !fifo_full_filter & (w_cnt<w_total); f_src_ready = (STREAM|FEAT_STREAM) & !fifo_full_fmap & (f_cnt<f_words); both combinational.
REQ-017 Transfer = valid & ready; weight_in_en/feature_in_en equal the respective transfer, weight_in/feature_in pass src data through combinationally; zero latency.
REQ-018 Each transfer increments its counter by 1; counters never exceed their totals; fifo_full high on a cycle blocks that cycle's transfer.
REQ-019 STREAM exits when w_cnt==w_total and f_cnt==f_words; FEAT_STREAM exits when f_cnt==f_words; f_cnt clears on exit.
REQ-020 On stream exit: pass_idx+1<n_pass -> pass_idx++, WAIT_SHIFT; else WAIT_CLIP.
REQ-021 shift_seen sticky latch: set by shift_finish_flg in STREAM/FEAT_STREAM/WAIT_SHIFT; WAIT_SHIFT leaves to FEAT_START when shift_seen|shift_finish_flg; cleared on leaving WAIT_SHIFT.
REQ-022 FEAT_START: start_feature_load=1 one cycle -> FEAT_STREAM.
REQ-023 clip_seen sticky latch likewise from clip_finish_flg in any non-IDLE state; WAIT_CLIP leaves to PSUM_OUT when clip_seen|clip_finish_flg.
REQ-024 PSUM_OUT: start_psum_out=1 one cycle -> DONE; DONE: done=1 one cycle -> IDLE.
REQ-025 busy=1 in every state except IDLE.
REQ-026 n_pass=0 treated as 1; w_total=0 skips weight streaming; f_words=0 passes stream nothing but still wait for shift.
REQ-027 abort=1 in any state -> IDLE next cycle, counters/latches cleared, no done pulse; abort has priority over go.
REQ-028 All control pulses are registered-state decodes, glitch-free, never two consecutive cycles.

Reset
REQ-029 rst=0 asynchronously forces IDLE; all counters, latches, pass_idx = 0; all outputs 0 (ready/en low, data outputs 0).
REQ-030 Release of rst takes effect on first clk edge; no pulse issued on release.

Verification
REQ-031 Mode-1 nominal: w_total=102, f_words=12, n_pass=3, sources always valid, fifo never full -> one start_config, 102 weight writes, 3 start_feature_load pulses, 36 fmap writes, start_psum_out 1 cycle after clip seen, done once.
REQ-032 Backpressure: fifo_full_filter toggled high 1 of every 3 cycles -> no weight_in_en while full, exactly 102 writes, order 1..102 preserved.
REQ-033 Early flags: shift_finish_flg pulses during STREAM -> WAIT_SHIFT exits in 1 cycle; clip_finish_flg pulses during last FEAT_STREAM -> PSUM_OUT immediately after stream end.
REQ-034 Abort mid-stream after 40 weight words -> IDLE next cycle, readies low, busy low, no done; new go restarts at w_cnt=0.
REQ-035 rst asserted in FEAT_STREAM -> all outputs 0 immediately, IDLE after release.
REQ-036 Corner: n_pass=0, w_total=0, f_words=4 -> single pass, 4 fmap writes, no weight writes, then WAIT_CLIP.
